// File: rtl/axi_burst_addr_arbiter_if.sv
// Bus bundle for axi_burst_addr_arbiter: N upstream address channels, one downstream channel,
// the beat-end handshake and the exported grant. The arbiter binds the slave modport.
`ifndef BW_AXI_ALEN
`define BW_AXI_ALEN 8
`endif
`ifndef BW_AXI_ASIZE
`define BW_AXI_ASIZE 3
`endif
`ifndef BW_AXI_ABURST
`define BW_AXI_ABURST 2
`endif

interface axi_burst_addr_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int BW_ADDR  = 32,
  parameter int BW_ID    = 4,
  parameter int BW_INDEX = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]                s_avalid;
  logic [NUM_REQ-1:0]                s_aready;
  logic [NUM_REQ*BW_ID-1:0]          s_aid;
  logic [NUM_REQ*BW_ADDR-1:0]        s_aaddr;
  logic [NUM_REQ*`BW_AXI_ALEN-1:0]   s_alen;
  logic [NUM_REQ*`BW_AXI_ASIZE-1:0]  s_asize;
  logic [NUM_REQ*`BW_AXI_ABURST-1:0] s_aburst;
  logic                              m_avalid;
  logic                              m_aready;
  logic [BW_ID-1:0]                  m_aid;
  logic [BW_ADDR-1:0]                m_aaddr;
  logic [`BW_AXI_ALEN-1:0]           m_alen;
  logic [`BW_AXI_ASIZE-1:0]          m_asize;
  logic [`BW_AXI_ABURST-1:0]         m_aburst;
  logic                              beat_valid;
  logic                              beat_ready;
  logic                              beat_last;
  logic                              grant_valid;
  logic [BW_INDEX-1:0]               grant_index;

  modport slave (
    input  s_avalid, s_aid, s_aaddr, s_alen, s_asize, s_aburst,
    input  m_aready, beat_valid, beat_ready, beat_last,
    output s_aready, m_avalid, m_aid, m_aaddr, m_alen, m_asize, m_aburst,
    output grant_valid, grant_index
  );

  modport master (
    output s_avalid, s_aid, s_aaddr, s_alen, s_asize, s_aburst,
    output m_aready, beat_valid, beat_ready, beat_last,
    input  s_aready, m_avalid, m_aid, m_aaddr, m_alen, m_asize, m_aburst,
    input  grant_valid, grant_index
  );
endinterface

// File: rtl/axi_burst_addr_arbiter.sv
// Shares one burst address generator among NUM_REQ AXI address channels, one burst at a time.
// Define BURST_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
`ifndef BW_AXI_ALEN
`define BW_AXI_ALEN 8
`endif
`ifndef BW_AXI_ASIZE
`define BW_AXI_ASIZE 3
`endif
`ifndef BW_AXI_ABURST
`define BW_AXI_ABURST 2
`endif

module axi_burst_addr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int BW_ADDR = 32,
  parameter int BW_ID   = 4
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    clear,
  input  logic                    enable,
  axi_burst_addr_arbiter_if.slave bus
);
  localparam int BW_INDEX = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [BW_INDEX-1:0] grant_q, grant_d;
  logic [BW_INDEX-1:0] rr_q, rr_d;
  logic                beat_end;

  // First requesting index at or above ptr, wrapping modulo NUM_REQ.
  function automatic logic [BW_INDEX-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                       input logic [BW_INDEX-1:0] ptr);
    logic [BW_INDEX-1:0] win;
    int                  idx;
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) win = BW_INDEX'(idx);
    end
    return win;
  endfunction

  function automatic logic [BW_INDEX-1:0] next_ptr(input logic [BW_INDEX-1:0] owner);
`ifdef BURST_ARB_FIXED_PRIORITY_EN
    return (owner == owner) ? '0 : '0;
`else
    return (owner == BW_INDEX'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif
  endfunction

  assign beat_end = bus.beat_valid & bus.beat_ready & bus.beat_last;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    if (clear) begin
      state_d = IDLE;
      rr_d    = '0;
    end else if (enable) begin
      unique case (state_q)
        IDLE: if (|bus.s_avalid) begin
          grant_d = pick_winner(bus.s_avalid, rr_q);
          state_d = ISSUE;
        end
        ISSUE: if (bus.m_aready) state_d = BUSY;
        BUSY: if (beat_end) begin
          state_d = IDLE;
          rr_d    = next_ptr(grant_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Only the owner sees ready, and only while its address is still outstanding.
  always_comb begin
    bus.s_aready = '0;
    if (state_q == ISSUE) bus.s_aready[grant_q] = bus.m_aready & enable;
  end

  assign bus.m_avalid    = (state_q == ISSUE) & enable;
  assign bus.m_aid       = bus.s_aid[int'(grant_q)*BW_ID +: BW_ID];
  assign bus.m_aaddr     = bus.s_aaddr[int'(grant_q)*BW_ADDR +: BW_ADDR];
  assign bus.m_alen      = bus.s_alen[int'(grant_q)*`BW_AXI_ALEN +: `BW_AXI_ALEN];
  assign bus.m_asize     = bus.s_asize[int'(grant_q)*`BW_AXI_ASIZE +: `BW_AXI_ASIZE];
  assign bus.m_aburst    = bus.s_aburst[int'(grant_q)*`BW_AXI_ABURST +: `BW_AXI_ABURST];
  assign bus.grant_valid = (state_q != IDLE);
  assign bus.grant_index = grant_q;
endmodule
